runahead_issue_arbiter: RTL and testbench

RUNAHEAD_ISSUE_ARBITER -- requirements
Module: runahead_issue_arbiter

---
 rtl/runahead_pkg.sv | 18 +
 rtl/runahead_fetch_fifo.sv | 65 ++++++
 rtl/runahead_issue_arbiter.sv | 145 ++++++++++++++
 tb/tb_runahead_issue_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/runahead_pkg.sv
// Shared definitions for the runahead issue arbiter.
//   DEFAULT_INSTR_WIDTH : default instruction width in bits
//   issue_src_e         : origin of an issued instruction (FETCHED / RUNAHEAD)
//   chan_width()        : width of a channel index, never less than 1
package runahead_pkg;

    localparam int unsigned DEFAULT_INSTR_WIDTH = 16;

    typedef enum logic {
        FETCHED  = 1'b0,
        RUNAHEAD = 1'b1
    } issue_src_e;

    function automatic int unsigned chan_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/runahead_fetch_fifo.sv
// Fetched-instruction FIFO with valid/ready on both sides.
//   clk, sync_rst       : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : push side; ready also while full if a pop happens
//   out_valid/out_ready/out_data : pop side; head is presented straight from storage
//   count               : current occupancy (0..DEPTH)
module runahead_fetch_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     sync_rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign in_ready  = ~sync_rst & ((count != CW'(DEPTH)) | pop);
    assign push      = in_valid & in_ready;

    // Storage needs no reset; occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/runahead_issue_arbiter.sv
// Issue arbiter between a fetched-instruction FIFO and runahead channels.
//   clk, sync_rst                    : clock, synchronous active-high reset
//   fetch_valid/fetch_ready/fetch_instr : fetched instructions into the FIFO
//   ra_valid/ra_ready/ra_instr       : runahead channels, channel i in slice i
//   out_valid/out_ready/out_instr    : single-stage registered issue port
//   out_is_runahead, out_channel     : source of the issued instruction
//   fetch_count                      : fetched FIFO occupancy
// Runahead work wins, round-robin across channels, but after MAX_RA_BURST
// consecutive runahead issues with fetched work waiting the FIFO head goes.
module runahead_issue_arbiter
    import runahead_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = DEFAULT_INSTR_WIDTH,
    parameter int unsigned RA_CHANNELS  = 2,
    parameter int unsigned FETCH_DEPTH  = 4,
    parameter int unsigned MAX_RA_BURST = 4
) (
    input  logic                                 clk,
    input  logic                                 sync_rst,
    input  logic                                 fetch_valid,
    output logic                                 fetch_ready,
    input  logic [INSTR_WIDTH-1:0]               fetch_instr,
    input  logic [RA_CHANNELS-1:0]               ra_valid,
    output logic [RA_CHANNELS-1:0]               ra_ready,
    input  logic [RA_CHANNELS*INSTR_WIDTH-1:0]   ra_instr,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [INSTR_WIDTH-1:0]               out_instr,
    output logic                                 out_is_runahead,
    output logic [chan_width(RA_CHANNELS)-1:0]   out_channel,
    output logic [$clog2(FETCH_DEPTH):0]         fetch_count
);

    localparam int unsigned CH_W    = chan_width(RA_CHANNELS);
    localparam int unsigned BURST_W = $clog2(MAX_RA_BURST + 1);

    logic                   head_valid;
    logic [INSTR_WIDTH-1:0] head_instr;
    logic                   load_en;
    logic                   force_fetch;
    logic                   grant_ra;
    logic                   grant_fetch;
    logic                   pick_found;
    logic [CH_W-1:0]        pick_idx;
    logic [CH_W-1:0]        rr_next;
    logic [INSTR_WIDTH-1:0] pick_instr;
    logic [CH_W-1:0]        rr_ptr;
    logic [BURST_W-1:0]     burst_cnt;
    issue_src_e             src_q;

    runahead_fetch_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FETCH_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .in_valid  (fetch_valid),
        .in_ready  (fetch_ready),
        .in_data   (fetch_instr),
        .out_valid (head_valid),
        .out_ready (grant_fetch),
        .out_data  (head_instr),
        .count     (fetch_count)
    );

    // Round-robin pick: first valid channel at or above rr_ptr, else lowest valid.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned c = 0; c < RA_CHANNELS; c++) begin
            if (!pick_found && ra_valid[c] && (CH_W'(c) >= rr_ptr)) begin
                pick_found = 1'b1;
                pick_idx   = CH_W'(c);
            end
        end
        for (int unsigned c = 0; c < RA_CHANNELS; c++) begin
            if (!pick_found && ra_valid[c]) begin
                pick_found = 1'b1;
                pick_idx   = CH_W'(c);
            end
        end
    end

    // Data mux for the picked runahead channel.
    always_comb begin
        pick_instr = '0;
        for (int unsigned c = 0; c < RA_CHANNELS; c++) begin
            if (CH_W'(c) == pick_idx) begin
                pick_instr = ra_instr[c*INSTR_WIDTH +: INSTR_WIDTH];
            end
        end
    end

    assign rr_next = (pick_idx == CH_W'(RA_CHANNELS - 1)) ? '0 : pick_idx + CH_W'(1);

    // Grants only when the output stage can accept a new instruction.
    assign load_en     = ~sync_rst & (~out_valid | out_ready);
    assign force_fetch = (burst_cnt == BURST_W'(MAX_RA_BURST)) & head_valid;
    assign grant_ra    = load_en & pick_found & ~force_fetch;
    assign grant_fetch = load_en & head_valid & ~grant_ra;

    always_comb begin
        ra_ready = '0;
        if (grant_ra) begin
            ra_ready[pick_idx] = 1'b1;
        end
    end

    assign out_is_runahead = (src_q == RUNAHEAD);

    // Output stage, round-robin pointer and burst counter.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_channel <= '0;
            src_q       <= FETCHED;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
        end else begin
            if (load_en) begin
                out_valid <= grant_ra | grant_fetch;
                if (grant_ra) begin
                    out_instr   <= pick_instr;
                    out_channel <= pick_idx;
                    src_q       <= RUNAHEAD;
                end else if (grant_fetch) begin
                    out_instr   <= head_instr;
                    out_channel <= '0;
                    src_q       <= FETCHED;
                end
            end
            if (grant_ra) begin
                rr_ptr <= rr_next;
            end
            // Burst only counts while fetched work is actually being held back.
            if (grant_fetch || !head_valid) begin
                burst_cnt <= '0;
            end else if (grant_ra && (burst_cnt != BURST_W'(MAX_RA_BURST))) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_runahead_issue_arbiter.sv
// Bench for runahead_issue_arbiter: table-driven vectors plus scoreboard sequences.
module tb_runahead_issue_arbiter;

    logic        clk = 1'b0;
    logic        sync_rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [15:0] fetch_instr;
    logic [1:0]  ra_valid;
    logic [1:0]  ra_ready;
    logic [31:0] ra_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic        out_is_runahead;
    logic [0:0]  out_channel;
    logic [2:0]  fetch_count;

    typedef struct packed {
        logic [15:0] instr;
        logic        is_ra;
        logic        ch;
    } exp_t;

    typedef struct {
        logic        fv;
        logic [15:0] fi;
        logic [1:0]  rv;
        logic [15:0] r0;
        logic [15:0] r1;
        logic        ordy;
        logic [1:0]  e_rdy;
        logic        e_ov;
        logic        chk_d;
        logic [15:0] e_instr;
        logic        e_ra;
        logic        e_ch;
        logic [2:0]  e_cnt;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    logic sb_en = 1'b0;

    runahead_issue_arbiter #(
        .INSTR_WIDTH  (16),
        .RA_CHANNELS  (2),
        .FETCH_DEPTH  (4),
        .MAX_RA_BURST (4)
    ) dut (
        .clk             (clk),
        .sync_rst        (sync_rst),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_instr     (fetch_instr),
        .ra_valid        (ra_valid),
        .ra_ready        (ra_ready),
        .ra_instr        (ra_instr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_is_runahead (out_is_runahead),
        .out_channel     (out_channel),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] instr, input logic is_ra, input logic ch);
        exp_t e;
        e.instr = instr;
        e.is_ra = is_ra;
        e.ch    = ch;
        sbq.push_back(e);
    endtask

    // Settle, score any issue transfer about to happen, then advance one clock.
    task automatic tick();
        exp_t e;
        #1;
        if (sb_en && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got issue 0x%0h expected none", out_instr);
            end else begin
                e = sbq.pop_front();
                chk("sb_issue", 32'({out_instr, out_is_runahead, out_channel}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   sent;
        int   cyc;
        logic acc;

        // in: fv fi rv r0 r1 ordy | exp: ra_ready ov chk_d instr ra ch cnt
        tbl[0] = '{1'b1, 16'h1234, 2'b00, 16'h0000, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1};
        tbl[1] = '{1'b0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b1, 2'b00, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 3'd0};
        tbl[2] = '{1'b0, 16'h0000, 2'b11, 16'hA000, 16'hB000, 1'b1, 2'b01, 1'b1, 1'b1, 16'hA000, 1'b1, 1'b0, 3'd0};
        tbl[3] = '{1'b0, 16'h0000, 2'b11, 16'hA000, 16'hB000, 1'b1, 2'b10, 1'b1, 1'b1, 16'hB000, 1'b1, 1'b1, 3'd0};
        tbl[4] = '{1'b0, 16'h0000, 2'b11, 16'hA000, 16'hB000, 1'b1, 2'b01, 1'b1, 1'b1, 16'hA000, 1'b1, 1'b0, 3'd0};
        tbl[5] = '{1'b0, 16'h0000, 2'b11, 16'hA000, 16'hB000, 1'b1, 2'b10, 1'b1, 1'b1, 16'hB000, 1'b1, 1'b1, 3'd0};
        tbl[6] = '{1'b0, 16'h0000, 2'b00, 16'hA000, 16'hB000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0};

        // Reset with all requesters active: nothing may be accepted.
        sync_rst    = 1'b1;
        fetch_valid = 1'b1;
        fetch_instr = 16'hDEAD;
        ra_valid    = 2'b11;
        ra_instr    = 32'hBEEF_CAFE;
        out_ready   = 1'b1;
        #1;
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("rst_ra_ready", 32'(ra_ready), 32'd0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", 32'(out_instr), 32'd0);
        chk("rst_out_is_ra", 32'(out_is_runahead), 32'd0);
        chk("rst_out_channel", 32'(out_channel), 32'd0);
        chk("rst_fetch_count", 32'(fetch_count), 32'd0);
        sync_rst    = 1'b0;
        fetch_valid = 1'b0;
        ra_valid    = 2'b00;
        tick();

        // Fetched latency and two-channel round-robin.
        for (int i = 0; i < 7; i++) begin
            fetch_valid = tbl[i].fv;
            fetch_instr = tbl[i].fi;
            ra_valid    = tbl[i].rv;
            ra_instr    = {tbl[i].r1, tbl[i].r0};
            out_ready   = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_ra_ready", i), 32'(ra_ready), 32'(tbl[i].e_rdy));
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d_fetch_count", i), 32'(fetch_count), 32'(tbl[i].e_cnt));
            if (tbl[i].chk_d) begin
                chk($sformatf("v%0d_out_instr", i), 32'(out_instr), 32'(tbl[i].e_instr));
                chk($sformatf("v%0d_out_is_ra", i), 32'(out_is_runahead), 32'(tbl[i].e_ra));
                chk($sformatf("v%0d_out_channel", i), 32'(out_channel), 32'(tbl[i].e_ch));
            end
        end

        // Burst limit: four runahead issues, then the waiting fetched entry.
        push_exp(16'hC0DE, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push_exp(16'hA000, 1'b1, 1'b0);
        push_exp(16'h0001, 1'b0, 1'b0);
        push_exp(16'hA000, 1'b1, 1'b0);
        push_exp(16'hA000, 1'b1, 1'b0);
        sb_en       = 1'b1;
        out_ready   = 1'b0;
        ra_valid    = 2'b01;
        ra_instr    = {16'h0000, 16'hC0DE};
        tick();
        ra_valid    = 2'b00;
        fetch_valid = 1'b1;
        fetch_instr = 16'h0001;
        tick();
        fetch_valid = 1'b0;
        ra_valid    = 2'b01;
        ra_instr    = {16'h0000, 16'hA000};
        out_ready   = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        ra_valid = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        chk("burst_left", 32'(sbq.size()), 32'd0);

        // Stall: fill the FIFO behind a held output, then push and pop together.
        out_ready = 1'b0;
        ra_valid  = 2'b10;
        ra_instr  = {16'h5555, 16'h0000};
        tick();
        ra_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1;
            fetch_instr = 16'h0100 + 16'(i);
            tick();
            chk("hold_out_instr", 32'(out_instr), 32'h5555);
        end
        fetch_instr = 16'h0104;
        ra_valid    = 2'b11;
        #1;
        chk("full_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("full_fetch_count", 32'(fetch_count), 32'd4);
        chk("stall_ra_ready", 32'(ra_ready), 32'd0);
        ra_valid = 2'b00;
        tick();
        chk("hold5_out_valid", 32'(out_valid), 32'd1);
        chk("hold5_out_instr", 32'(out_instr), 32'h5555);
        chk("hold5_out_is_ra", 32'(out_is_runahead), 32'd1);
        chk("hold5_out_channel", 32'(out_channel), 32'd1);
        push_exp(16'h5555, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) push_exp(16'h0100 + 16'(i), 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("full_pop_fetch_ready", 32'(fetch_ready), 32'd1);
        tick();
        chk("pushpop_fetch_count", 32'(fetch_count), 32'd4);
        fetch_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("hold_left", 32'(sbq.size()), 32'd0);

        // Reset with work in flight: nothing stale may issue afterwards.
        out_ready = 1'b0;
        ra_valid  = 2'b01;
        ra_instr  = {16'h0000, 16'h7777};
        tick();
        ra_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1;
            fetch_instr = 16'h0300 + 16'(i);
            tick();
        end
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_fetch_count", 32'(fetch_count), 32'd3);
        sync_rst    = 1'b1;
        fetch_instr = 16'h0399;
        #1;
        chk("mid_rst_fetch_ready", 32'(fetch_ready), 32'd0);
        tick();
        sync_rst    = 1'b0;
        fetch_valid = 1'b0;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_fetch_count", 32'(fetch_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_idle", 32'(out_valid), 32'd0);

        // Pointer wrap: 20 sequential values with random back-pressure.
        for (int i = 0; i < 20; i++) push_exp(16'h0200 + 16'(i), 1'b0, 1'b0);
        sent = 0;
        cyc  = 0;
        while (sent < 20 && cyc < 400) begin
            fetch_valid = 1'b1;
            fetch_instr = 16'h0200 + 16'(sent);
            out_ready   = 1'($urandom_range(0, 1));
            #1;
            acc = fetch_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        fetch_valid = 1'b0;
        out_ready   = 1'b1;
        cyc = 0;
        while (sbq.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        chk("wrap_sent", 32'(sent), 32'd20);
        chk("wrap_left", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
